// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 core
// Revision : 1.0
// ============================================================================
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             halted,
    output logic             error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'((TIMEOUT < 1) ? 1 : TIMEOUT);

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [6:0]       op_q, op_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [TMO_W-1:0] tmo_inc;
    logic             tmo_expired;

    assign tmo_inc     = tmo_q + TMO_W'(1);
    assign tmo_expired = (tmo_inc == TMO_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            op_q      <= '0;
            error_q   <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            op_q      <= op_d;
            error_q   <= error_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        op_d      = op_q;
        error_d   = error_q;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        dmem_req  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (tmo_expired) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            // Later stages work from op_q so a changing IR input cannot redirect them.
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_RTYPE, OP_LOAD, OP_STORE, OP_BEQ: state_d = S_EXEC;
                    OP_ECALL: state_d = S_HALT;
                    default: begin
                        state_d = S_HALT;
                        error_d = 1'b1;
                    end
                endcase
            end

            S_EXEC: begin
                case (op_q)
                    OP_BEQ: begin
                        pc_write = 1'b1;
                        pc_src   = zero;
                        state_d  = S_FETCH;
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_RTYPE:          state_d = S_WB;
                    default: begin
                        state_d = S_HALT;
                        error_d = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (op_q == OP_LOAD);
                mem_write = (op_q == OP_STORE);
                if (dmem_ready) begin
                    if (op_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (tmo_expired) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_HALT;
                error_d = 1'b1;
            end
        endcase

        if (state_d != state_q) begin
            tmo_d = '0;
        end

        cycle_d = cycle_q;
        if (state_q != S_IDLE && state_q != S_HALT) begin
            cycle_d = cycle_q + CNT_W'(1);
        end

        instret_d = instret_q;
        if (pc_write) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    assign halted      = (state_q == S_HALT);
    assign error       = error_q;
    assign state       = state_q;
    assign cycle_count = cycle_q;
    assign instret     = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Self-checking bench: per-instruction expected traces vs the sequencer
// Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl;

    localparam int TMO = 4;

    localparam logic [9:0] F_IMREQ = 10'h200;
    localparam logic [9:0] F_IRW   = 10'h100;
    localparam logic [9:0] F_DREQ  = 10'h080;
    localparam logic [9:0] F_MRD   = 10'h040;
    localparam logic [9:0] F_MWR   = 10'h020;
    localparam logic [9:0] F_REGW  = 10'h010;
    localparam logic [9:0] F_PCW   = 10'h008;
    localparam logic [9:0] F_PCSRC = 10'h004;
    localparam logic [9:0] F_HALT  = 10'h002;
    localparam logic [9:0] F_ERR   = 10'h001;

    localparam int OP_R = 51, OP_L = 3, OP_S = 35, OP_B = 99, OP_EC = 115, OP_ILL = 23;

    logic        clk = 1'b0;
    logic        reset, run, zero, imem_ready, dmem_ready;
    logic [6:0]  opcode;
    logic        imem_req, ir_write, dmem_req, mem_read, mem_write;
    logic        reg_write, pc_write, pc_src, halted, error;
    logic [2:0]  state;
    logic [31:0] cycle_count, instret;
    logic [9:0]  dut_outs;

    multicycle_ctrl #(.CNT_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .pc_write(pc_write), .pc_src(pc_src), .halted(halted), .error(error),
        .state(state), .cycle_count(cycle_count), .instret(instret)
    );

    always #5 clk = ~clk;

    assign dut_outs = {imem_req, ir_write, dmem_req, mem_read, mem_write,
                       reg_write, pc_write, pc_src, halted, error};

    typedef struct {
        logic [2:0] st;
        logic [9:0] outs;
        logic       rn;
        logic [6:0] op;
        logic       z;
        logic       imr;
        logic       dmr;
    } ent_t;

    ent_t        plan[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cyc, exp_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Negative values request a random (don't-care) input for that cycle.
    task automatic push(input int st, input logic [9:0] outs, input int rn, input int op,
                        input int z, input int imr, input int dmr);
        ent_t e;
        e.st   = 3'(st);
        e.outs = outs;
        e.rn   = (rn  < 0) ? 1'($urandom_range(0, 1)) : 1'(rn);
        e.op   = (op  < 0) ? 7'($urandom)             : 7'(op);
        e.z    = (z   < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
        e.imr  = (imr < 0) ? 1'($urandom_range(0, 1)) : 1'(imr);
        e.dmr  = (dmr < 0) ? 1'($urandom_range(0, 1)) : 1'(dmr);
        plan.push_back(e);
    endtask

    // kind: 0 R-type, 1 load, 2 store, 3 BEQ; wi/wd are ready wait cycles
    task automatic plan_instr(input int kind, input int wi, input int wd);
        int         op;
        int         z;
        logic [9:0] mflag;
        op = (kind == 0) ? OP_R : (kind == 1) ? OP_L : (kind == 2) ? OP_S : OP_B;
        for (int i = 0; i < wi; i++) push(1, F_IMREQ, -1, -1, -1, 0, -1);
        push(1, F_IMREQ | F_IRW, -1, -1, -1, 1, -1);
        push(2, 10'h0, -1, op, -1, -1, -1);
        if (kind == 3) begin
            z = int'($urandom_range(0, 1));
            push(3, F_PCW | ((z != 0) ? F_PCSRC : 10'h0), -1, -1, z, -1, -1);
        end else begin
            push(3, 10'h0, -1, -1, -1, -1, -1);
        end
        if (kind == 1 || kind == 2) begin
            mflag = (kind == 1) ? F_MRD : F_MWR;
            for (int i = 0; i < wd; i++) push(4, F_DREQ | mflag, -1, -1, -1, -1, 0);
            push(4, F_DREQ | mflag | ((kind == 2) ? F_PCW : 10'h0), -1, -1, -1, -1, 1);
        end
        if (kind == 0 || kind == 1) push(5, F_REGW | F_PCW, -1, -1, -1, -1, -1);
    endtask

    task automatic run_plan;
        ent_t e;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            @(negedge clk);
            run        = e.rn;
            opcode     = e.op;
            zero       = e.z;
            imem_ready = e.imr;
            dmem_ready = e.dmr;
            #1;
            chk("state", 32'(state), 32'(e.st));
            chk("enables", 32'(dut_outs), 32'(e.outs));
            chk("cycle_count", cycle_count, exp_cyc);
            chk("instret", instret, exp_ret);
            if (e.st != 3'd0 && e.st != 3'd6) exp_cyc = exp_cyc + 1;
            if ((e.outs & F_PCW) != 10'h0) exp_ret = exp_ret + 1;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'(dut_outs), 32'd0);
        chk("rst_cycles", cycle_count, 32'd0);
        chk("rst_instret", instret, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        exp_cyc = '0;
        exp_ret = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0; opcode = '0; zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        exp_cyc = '0; exp_ret = '0;

        // Two back-to-back R-type instructions with immediate memory
        do_reset();
        push(0, 10'h0, 1, -1, -1, -1, -1);
        plan_instr(0, 0, 0);
        plan_instr(0, 0, 0);
        run_plan();
        @(posedge clk);
        #1;
        chk("instret_after_2r", instret, 32'd2);
        chk("cycles_after_2r", cycle_count, 32'd8);

        // Directed load/store waits and branches, then a random mix
        plan_instr(1, 0, 3);
        plan_instr(2, 1, 2);
        plan_instr(3, 0, 0);
        plan_instr(3, 2, 0);
        for (int n = 0; n < 16; n++)
            plan_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, TMO - 1)),
                       int'($urandom_range(0, TMO - 1)));

        // Fetch timeout: TMO cycles without imem_ready, then sticky error halt
        for (int i = 0; i < TMO; i++) push(1, F_IMREQ, -1, -1, -1, 0, -1);
        for (int i = 0; i < 4; i++) push(6, F_HALT | F_ERR, -1, -1, -1, -1, -1);
        run_plan();

        // ECALL: clean halt
        do_reset();
        push(0, 10'h0, 1, -1, -1, -1, -1);
        push(1, F_IMREQ | F_IRW, -1, -1, -1, 1, -1);
        push(2, 10'h0, -1, OP_EC, -1, -1, -1);
        for (int i = 0; i < 3; i++) push(6, F_HALT, -1, -1, -1, -1, -1);
        run_plan();

        // Illegal opcode (AUIPC here): error halt
        do_reset();
        push(0, 10'h0, 1, -1, -1, -1, -1);
        push(1, F_IMREQ | F_IRW, -1, -1, -1, 1, -1);
        push(2, 10'h0, -1, OP_ILL, -1, -1, -1);
        for (int i = 0; i < 3; i++) push(6, F_HALT | F_ERR, -1, -1, -1, -1, -1);
        run_plan();

        // Asynchronous reset while a load waits in MEM
        do_reset();
        push(0, 10'h0, 1, -1, -1, -1, -1);
        push(1, F_IMREQ | F_IRW, -1, -1, -1, 1, -1);
        push(2, 10'h0, -1, OP_L, -1, -1, -1);
        push(3, 10'h0, -1, -1, -1, -1, -1);
        push(4, F_DREQ | F_MRD, -1, -1, -1, -1, 0);
        push(4, F_DREQ | F_MRD, -1, -1, -1, -1, 0);
        run_plan();
        #2;
        reset = 1'b1;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_outs", 32'(dut_outs), 32'd0);
        chk("async_cycles", cycle_count, 32'd0);
        chk("async_instret", instret, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        run     = 1'b0;
        exp_cyc = '0;
        exp_ret = '0;
        push(0, 10'h0, 0, -1, -1, -1, -1);
        push(0, 10'h0, 0, -1, -1, -1, -1);
        push(0, 10'h0, 1, -1, -1, -1, -1);
        plan_instr(0, 1, 0);
        run_plan();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
